dht_single_wire_reader: RTL and testbench
=========================================

// Module: dht_single_wire_reader
// PURPOSE
// Parametrised single-wire humidity/temperature sensor reader for the DHT11 and DHT22 families.
// Runs on the system clock; no divided clock. A microsecond tick paces all protocol timing.
// Sequence: host start pulse, sensor response, 40 data bits, checksum check, bounded automatic retry.
// The UART command layer sits above it and reads result/status; the FPGA pin sits below it.
// PARAMETERS
// CLK_FREQ_HZ      50_000_000  system clock frequency; sets the 1 us tick divisor (must divide by 1e6)
// START_LOW_DHT11  19000       host start-low time in us, mode 0
// START_LOW_DHT22  1100        host start-low time in us, mode 1
// RELEASE_US       30          host drives high this long, then releases the line
// BIT_ONE_US       50          high-phase length >= this decodes as '1'
// TIMEOUT_US       1000        max wait for any sensor edge
// GUARD_US         1_000_000   quiet time after each attempt, before retry or next start
// MAX_RETRIES      2           extra attempts after a failed one (0 = no retry)
// PORTS
// clock        in   1   system clock
// reset_n      in   1   asynchronous active-low reset
// start        in   1   1-cycle request; ignored while busy=1
// sensor_type  in   1   0=DHT11, 1=DHT22; sampled on accepted start
// dht_data     io   1   open-drain sensor line (drive 0/1 or 'z')
// data_out     out  40  {hum[15:0], temp[15:0], checksum[7:0]}; MSB first as received
// busy         out  1   high from accepted start through the final guard
// done         out  1   1-cycle pulse when the transaction ends (success or final failure)
// error        out  1   valid with done; 1 = all attempts failed
// error_code   out  3   0 ok, 1 no response, 2 resp-low timeout, 3 resp-high timeout, 4 bit timeout, 5 checksum
// attempts     out  2   attempts used in the last transaction (1..MAX_RETRIES+1, saturating)
// BEHAVIOUR
// Reset values:
//   - dht_data released ('z'); all outputs 0; FSM in IDLE.
//   - Reset mid-operation releases the line immediately and asynchronously.
// Input path:
//   - dht_data passes through a 2-flop synchronizer, then edge detectors.
//   - All sensor-edge decisions use the synchronized value (2-cycle latency).
// us_tick: one cycle high every CLK_FREQ_HZ/1e6 clocks. us_cnt (20 bit) advances on us_tick and clears on each state entry.
// FSM states and transitions:
//   - IDLE: on start with line high, latch sensor_type, attempts=1 -> START_LOW. Start with line low: ignored.
//   - START_LOW: drive 0 for START_LOW_* us -> RELEASE.
//   - RELEASE: drive 1 for RELEASE_US us, then release -> RESP_WAIT.
//   - RESP_WAIT: wait for falling edge. Timeout -> FAIL, code 1.
//   - RESP_LOW: wait for rising edge. Timeout -> FAIL, code 2.
//   - RESP_HIGH: wait for falling edge. Timeout -> FAIL, code 3.
//   - BIT_LOW: wait for rising edge -> BIT_HIGH. Timeout -> FAIL, code 4.
//   - BIT_HIGH: on falling edge, shift in (us_cnt >= BIT_ONE_US); after bit 40 -> CHECK, else -> BIT_LOW. Timeout -> FAIL, code 4.
//   - CHECK: (b4+b3+b2+b1) mod 256 == b0 -> load data_out, GUARD_OK. Mismatch -> FAIL, code 5.
//   - FAIL: record code -> GUARD_RETRY.
//   - GUARD_*: line released for GUARD_US.
//   - GUARD_RETRY: if attempts <= MAX_RETRIES, attempts++ -> START_LOW (bit counter and shift register cleared).
//     Otherwise pulse done, error=1 -> IDLE.
//   - GUARD_OK: pulse done, error=0, code 0 -> IDLE.
// Result registers:
//   - data_out is updated only on checksum pass and holds its value through later failed transactions.
//   - error and error_code hold until the next accepted start.
//   - busy=0 only in IDLE.
// Timing and counter rules:
//   - Timing tolerance is +/-1 us (tick phase).
//   - Bit counter is 6 bit. Exactly 40 bits are shifted; the sensor's trailing release edge is not required.
// STRUCTURE
// Shared package/include (dht_defs.vh): state encodings, error codes, sensor-type constants.
// Sub-module: dht_us_tick (parameter CLK_FREQ_HZ; in clock, reset_n; out tick).
// Tri-state: assign dht_data = oe ? drv : 1'bz;
// TESTING
// Behavioural sensor model on dht_data (pull-up), CLK_FREQ_HZ=50e6, GUARD_US reduced to 200 for sim.
// 1. DHT11 mode, model sends 0x37_00_19_00_50 -> done, error=0, data_out=0x3700190050, attempts=1; start-low lasts 19000 us.
// 2. DHT22 mode, model sends 0x02_8C_80_65_73 -> data_out=0x028C806573; start-low 1100 us.
// 3. Model silent -> each attempt times out at RESP_WAIT; done after 3 attempts, error=1, code=1, attempts=3.
// 4. First attempt with bad checksum (0x37_00_19_00_51), second good -> error=0, attempts=2, data_out from second.
// 5. Model stops after bit 17 -> code 4; start pulses while busy are ignored (no extra transaction).
// 6. reset_n asserted during START_LOW -> line 'z' in same cycle; outputs 0; next start runs a clean transaction.

Source files
------------

// File: rtl/dht_single_wire_reader_pkg.sv
// dht_single_wire_reader_pkg: shared state encodings, error codes, sensor types.
// Also holds the frame checksum helper used by the reader.
package dht_single_wire_reader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_RESP_WAIT,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_FAIL,
        S_GUARD_RETRY,
        S_GUARD_OK
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_NO_RESP   = 3'd1,
        ERR_RESP_LOW  = 3'd2,
        ERR_RESP_HIGH = 3'd3,
        ERR_BIT       = 3'd4,
        ERR_CHECKSUM  = 3'd5
    } err_t;

    localparam logic SENSOR_DHT11 = 1'b0;
    localparam logic SENSOR_DHT22 = 1'b1;

    localparam int FRAME_BITS = 40;

    function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// dht_us_tick: one-cycle pulse every CLK_FREQ_HZ/1e6 clocks (1 us pacing).
// Ports: clock, reset_n (async, active low) in; tick out.
module dht_us_tick #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht_single_wire_reader.sv
// dht_single_wire_reader: DHT11/DHT22 reader with checksum check and bounded retry.
// Ports: clock, reset_n, start, sensor_type in; dht_data open-drain; data_out/busy/done/error/error_code/attempts out.
module dht_single_wire_reader
    import dht_single_wire_reader_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int START_LOW_DHT11 = 19000,
    parameter int START_LOW_DHT22 = 1100,
    parameter int RELEASE_US      = 30,
    parameter int BIT_ONE_US      = 50,
    parameter int TIMEOUT_US      = 1000,
    parameter int GUARD_US        = 1_000_000,
    parameter int MAX_RETRIES     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sensor_type,
    inout  wire         dht_data,
    output logic [39:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  error_code,
    output logic [1:0]  attempts
);
    localparam logic [19:0] T_SL11  = 20'(START_LOW_DHT11);
    localparam logic [19:0] T_SL22  = 20'(START_LOW_DHT22);
    localparam logic [19:0] T_REL   = 20'(RELEASE_US);
    localparam logic [19:0] T_ONE   = 20'(BIT_ONE_US);
    localparam logic [19:0] T_TMO   = 20'(TIMEOUT_US);
    localparam logic [19:0] T_GUARD = 20'(GUARD_US);
    localparam logic [1:0]  MAX_ATT = 2'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic        tick;
    logic [19:0] us_cnt, low_us;
    logic [1:0]  sync_q;
    logic        lvl_q, line_hi, fall, rise;
    logic        type_q;
    logic [5:0]  bit_cnt;
    logic [39:0] shreg;
    logic [2:0]  fail_code_q, code_d;
    logic        accept, retry, shift_en, load, set_code;
    logic        fin_ok, fin_fail, oe, drv;
    logic        timeout, guard_end, bit_val;

    dht_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign line_hi   = sync_q[1];
    assign fall      = lvl_q & ~line_hi;
    assign rise      = ~lvl_q & line_hi;
    assign low_us    = (type_q == SENSOR_DHT22) ? T_SL22 : T_SL11;
    assign timeout   = us_cnt >= T_TMO;
    assign guard_end = us_cnt >= T_GUARD;
    assign bit_val   = us_cnt >= T_ONE;

    // Line is only driven while state says so, so an async reset frees it at once.
    assign oe       = (state_q == S_START_LOW) || (state_q == S_RELEASE);
    assign drv      = (state_q == S_RELEASE);
    assign dht_data = oe ? drv : 1'bz;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        retry    = 1'b0;
        shift_en = 1'b0;
        load     = 1'b0;
        set_code = 1'b0;
        fin_ok   = 1'b0;
        fin_fail = 1'b0;
        code_d   = fail_code_q;
        unique case (state_q)
            S_IDLE: if (start && line_hi) begin
                accept  = 1'b1;
                state_d = S_START_LOW;
            end
            S_START_LOW: if (us_cnt >= low_us) state_d = S_RELEASE;
            S_RELEASE:   if (us_cnt >= T_REL) state_d = S_RESP_WAIT;
            S_RESP_WAIT: if (fall) state_d = S_RESP_LOW;
                else if (timeout) begin
                    set_code = 1'b1;
                    code_d   = ERR_NO_RESP;
                    state_d  = S_FAIL;
                end
            S_RESP_LOW: if (rise) state_d = S_RESP_HIGH;
                else if (timeout) begin
                    set_code = 1'b1;
                    code_d   = ERR_RESP_LOW;
                    state_d  = S_FAIL;
                end
            S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;
                else if (timeout) begin
                    set_code = 1'b1;
                    code_d   = ERR_RESP_HIGH;
                    state_d  = S_FAIL;
                end
            S_BIT_LOW: if (rise) state_d = S_BIT_HIGH;
                else if (timeout) begin
                    set_code = 1'b1;
                    code_d   = ERR_BIT;
                    state_d  = S_FAIL;
                end
            // 40th falling edge ends the frame; trailing release is not awaited.
            S_BIT_HIGH: if (fall) begin
                    shift_en = 1'b1;
                    state_d  = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (timeout) begin
                    set_code = 1'b1;
                    code_d   = ERR_BIT;
                    state_d  = S_FAIL;
                end
            S_CHECK: if (checksum_ok(shreg)) begin
                    load    = 1'b1;
                    state_d = S_GUARD_OK;
                end else begin
                    set_code = 1'b1;
                    code_d   = ERR_CHECKSUM;
                    state_d  = S_FAIL;
                end
            S_FAIL: state_d = S_GUARD_RETRY;
            S_GUARD_RETRY: if (guard_end) begin
                    if (attempts <= MAX_ATT) begin
                        retry   = 1'b1;
                        state_d = S_START_LOW;
                    end else begin
                        fin_fail = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            S_GUARD_OK: if (guard_end) begin
                    fin_ok  = 1'b1;
                    state_d = S_IDLE;
                end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            us_cnt  <= '0;
            // Idle line is high; presetting avoids a false edge after reset.
            sync_q  <= 2'b11;
            lvl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], dht_data};
            lvl_q   <= line_hi;
            if (state_q != state_d) us_cnt <= '0;
            else if (tick && us_cnt != '1) us_cnt <= us_cnt + 20'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            type_q      <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            fail_code_q <= '0;
            data_out    <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= '0;
            attempts    <= '0;
        end else begin
            done <= fin_ok | fin_fail;
            if (accept) begin
                type_q     <= sensor_type;
                attempts   <= 2'd1;
                error      <= 1'b0;
                error_code <= '0;
            end else if (retry && attempts != 2'd3) begin
                attempts <= attempts + 2'd1;
            end
            if (accept || retry) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 6'd1;
                shreg   <= {shreg[38:0], bit_val};
            end
            if (set_code) fail_code_q <= code_d;
            if (load) data_out <= shreg;
            if (fin_fail) begin
                error      <= 1'b1;
                error_code <= fail_code_q;
            end
            if (fin_ok) begin
                error      <= 1'b0;
                error_code <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_dht_single_wire_reader.sv
// tb_dht_single_wire_reader: sensor model on a pulled-up line, scoreboard of
// expected transaction results, directed cases then randomized attempt plans.
`timescale 1ns/1ps
module tb_dht_single_wire_reader;

    localparam int CLK_HZ = 2_000_000;
    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int SL11   = 60;
    localparam int SL22   = 30;
    localparam int REL    = 5;
    localparam int ONE    = 7;
    localparam int TMO    = 30;
    localparam int GUARD  = 20;
    localparam int MAXR   = 2;
    localparam int LIMIT  = 9000;

    typedef enum int {P_FULL, P_SILENT, P_LOW, P_HIGH, P_PART} kind_t;

    typedef struct {
        kind_t       kind;
        logic [39:0] frame;
        int          nbits;
    } plan_t;

    typedef struct {
        logic        err;
        logic [2:0]  code;
        logic [1:0]  att;
        logic [39:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        sensor_type = 1'b0;
    logic        sens_low = 1'b0;
    wire         dht_data;
    logic [39:0] data_out;
    logic        busy, done, error;
    logic [2:0]  error_code;
    logic [1:0]  attempts;

    assign dht_data = sens_low ? 1'b0 : 1'bz;
    pullup (dht_data);

    dht_single_wire_reader #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .START_LOW_DHT11(SL11),
        .START_LOW_DHT22(SL22),
        .RELEASE_US     (REL),
        .BIT_ONE_US     (ONE),
        .TIMEOUT_US     (TMO),
        .GUARD_US       (GUARD),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .sensor_type(sensor_type),
        .dht_data   (dht_data),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .error_code (error_code),
        .attempts   (attempts)
    );

    always #5 clock = ~clock;

    plan_t       planq[$];
    int          lowq[$];
    exp_t        expq[$];
    plan_t       cur[3];
    int          ncur;
    logic [39:0] model_data = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] mkframe(input logic [31:0] pl, input bit good);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'((pl >> (8 * k)) & 32'hFF);
        s = s % 256;
        if (!good) s = (s + 1 + int'($urandom_range(254))) % 256;
        return {pl, 8'(s)};
    endfunction

    function automatic int plan_code(input plan_t p);
        int s;
        s = 0;
        case (p.kind)
            P_FULL: begin
                for (int k = 1; k <= 4; k++)
                    s += int'((p.frame >> (8 * k)) & 40'hFF);
                return ((s % 256) == int'(p.frame & 40'hFF)) ? 0 : 5;
            end
            P_SILENT: return 1;
            P_LOW:    return 2;
            P_HIGH:   return 3;
            default:  return 4;
        endcase
    endfunction

    task automatic setp(input int i, input kind_t k, input logic [39:0] f,
                        input int nb);
        cur[i].kind  = k;
        cur[i].frame = f;
        cur[i].nbits = nb;
    endtask

    task automatic hold(input int us);
        repeat (us * DIV) @(negedge clock);
    endtask

    task automatic send(input plan_t p);
        case (p.kind)
            P_SILENT: ;
            P_LOW: begin
                sens_low = 1'b1; hold(TMO + 5); sens_low = 1'b0;
            end
            P_HIGH: begin
                sens_low = 1'b1; hold(10); sens_low = 1'b0;
            end
            default: begin
                sens_low = 1'b1; hold(10); sens_low = 1'b0; hold(10);
                for (int i = 0; i < p.nbits; i++) begin
                    sens_low = 1'b1; hold(8); sens_low = 1'b0;
                    hold(p.frame[39 - i] ? 12 : 3);
                end
                if (p.nbits == 40) begin
                    sens_low = 1'b1; hold(8); sens_low = 1'b0;
                end
            end
        endcase
    endtask

    // Sensor: answers every host start-low of at least 10 us with the next plan.
    initial begin : sensor
        int    lowc;
        int    e;
        plan_t p;
        forever begin
            @(negedge clock);
            if (dht_data === 1'b0) begin
                lowc = 0;
                while (dht_data === 1'b0) begin
                    lowc++;
                    @(negedge clock);
                end
                if (lowc >= 10 * DIV) begin
                    n_checks++;
                    if (lowq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_start: low %0d cycles, none expected", lowc);
                    end else begin
                        e = lowq.pop_front();
                        if (lowc < (e - 1) * DIV || lowc > (e + 1) * DIV) begin
                            n_fail++;
                            $display("FAIL start_low_len: got %0d cycles expected %0d..%0d",
                                     lowc, (e - 1) * DIV, (e + 1) * DIV);
                        end
                    end
                    if (planq.size() != 0) p = planq.pop_front();
                    else begin
                        p.kind = P_SILENT; p.frame = '0; p.nbits = 0;
                    end
                    hold(8);
                    send(p);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: done with no transaction pending");
                end else begin
                    e = expq.pop_front();
                    check("error", 64'(error), 64'(e.err));
                    check("error_code", 64'(error_code), 64'(e.code));
                    check("attempts", 64'(attempts), 64'(e.att));
                    check("data_out", 64'(data_out), 64'(e.data));
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic txn(input logic typ, input bit poke);
        exp_t e;
        int   c;
        int   cyc;
        for (int i = 0; i < ncur; i++) begin
            planq.push_back(cur[i]);
            lowq.push_back(typ ? SL22 : SL11);
        end
        c = plan_code(cur[ncur - 1]);
        e.att = 2'(ncur);
        if (c == 0) begin
            e.err  = 1'b0;
            e.code = 3'd0;
            e.data = cur[ncur - 1].frame;
            model_data = e.data;
        end else begin
            e.err  = 1'b1;
            e.code = 3'(c);
            e.data = model_data;
        end
        expq.push_back(e);
        @(negedge clock);
        start = 1'b1;
        sensor_type = typ;
        @(negedge clock);
        start = 1'b0;
        sensor_type = ~typ;
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            if (poke && busy === 1'b1 && (cyc % 300) == 150) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end else begin
                @(negedge clock);
            end
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
            expq.delete();
            planq.delete();
            lowq.delete();
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic gen_random();
        plan_t p;
        int    r;
        ncur = 0;
        for (int i = 0; i <= MAXR; i++) begin
            r = int'($urandom_range(9));
            p.nbits = 40;
            p.frame = mkframe($urandom, 1'b1);
            if (r < 4) p.kind = P_FULL;
            else if (r == 4) begin
                p.kind  = P_FULL;
                p.frame = mkframe($urandom, 1'b0);
            end else if (r == 5) p.kind = P_SILENT;
            else if (r == 6) p.kind = P_LOW;
            else if (r == 7) p.kind = P_HIGH;
            else begin
                p.kind  = P_PART;
                p.nbits = int'($urandom_range(39, 1));
            end
            cur[i] = p;
            ncur = i + 1;
            if (plan_code(p) == 0) break;
        end
    endtask

    initial begin : main
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_line", 64'(dht_data), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_code", 64'(error_code), 64'd0);
        check("rst_attempts", 64'(attempts), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        setp(0, P_FULL, 40'h37_00_19_00_50, 40);
        ncur = 1;
        txn(1'b0, 1'b0);

        setp(0, P_FULL, 40'h02_8C_80_65_73, 40);
        ncur = 1;
        txn(1'b1, 1'b0);

        for (int i = 0; i < 3; i++) setp(i, P_SILENT, '0, 0);
        ncur = 3;
        txn(1'b0, 1'b0);

        setp(0, P_FULL, 40'h37_00_19_00_51, 40);
        setp(1, P_FULL, 40'h37_00_19_00_50, 40);
        ncur = 2;
        txn(1'b0, 1'b0);

        for (int i = 0; i < 3; i++) setp(i, P_PART, 40'h02_8C_80_65_73, 17);
        ncur = 3;
        txn(1'b1, 1'b1);

        @(negedge clock);
        start = 1'b1;
        sensor_type = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("startlow_line", 64'(dht_data), 64'd0);
        check("startlow_busy", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_line", 64'(dht_data), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        check("midrst_code", 64'(error_code), 64'd0);
        check("midrst_attempts", 64'(attempts), 64'd0);
        check("midrst_data", 64'(data_out), 64'd0);
        model_data = '0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        setp(0, P_FULL, mkframe($urandom, 1'b1), 40);
        ncur = 1;
        txn(1'b0, 1'b0);

        repeat (10) begin
            gen_random();
            txn(1'($urandom_range(1)), 1'b0);
        end

        repeat (50) @(negedge clock);
        check("pending_results", 64'(expq.size()), 64'd0);
        check("pending_starts", 64'(lowq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
